// File: rtl/pulse_meter.sv
// pulse_meter: measures period and high time of a periodic single-bit
// waveform in clk cycles, with a timeout flag when the line stops toggling.
//
// Build option: define PULSE_METER_SYNC_EN to pass sig_in through a two-flop
// synchronizer (asynchronous sources). Without it sig_in is registered once
// (sources generated on clk). Measured values are identical in both builds;
// the synchronized build adds one cycle of latency.
module pulse_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;
  logic             sig_s;
  logic             sig_d;
  logic             rise;
  logic             fall;

  // ---- input capture stage ----
`ifdef PULSE_METER_SYNC_EN
  logic sig_meta;

  // Two-flop synchronizer; sig_s is the second flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_meta <= 1'b0;
      sig_s    <= 1'b0;
    end else begin
      sig_meta <= sig_in;
      sig_s    <= sig_meta;
    end
  end
`else
  // Single register of an input already generated on clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_s <= 1'b0;
    end else begin
      sig_s <= sig_in;
    end
  end
`endif

  // ---- edge detect stage ----
  // One-cycle delayed copy of sig_s for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;
  assign fall = ~sig_s & sig_d;

  // ---- measurement stage ----
  // Cycle counting FSM: the rise cycle counts as cycle 1; a rise closes the
  // running period and takes priority over the timeout check, so a period of
  // exactly TIMEOUT is still reported. cnt stops at TIMEOUT and never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt     <= ONE;
            timeout <= 1'b0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= cnt;
            high_time  <= hi_lat;
            meas_valid <= 1'b1;
            cnt        <= ONE;
          end else if (cnt == TMO_CNT) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            // Count before the increment equals the number of high cycles.
            if (fall) begin
              hi_lat <= cnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed bench for pulse_meter. Every clk cycle the DUT
// outputs are logged by cycle index; expected values are hand-computed from
// the drive sequence, offset by the build's output latency.
module tb_pulse_meter;

  localparam int CNT_W = 8;
  localparam int TMO   = 20;
`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int HMAX = 512;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic             mv_h [0:HMAX-1];
  logic             tm_h [0:HMAX-1];
  logic [CNT_W-1:0] p_h  [0:HMAX-1];
  logic [CNT_W-1:0] h_h  [0:HMAX-1];

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Drive sig_in for one cycle and log outputs just after the edge.
  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < HMAX) begin
      mv_h[cyc] = meas_valid;
      tm_h[cyc] = timeout;
      p_h[cyc]  = period;
      h_h[cyc]  = high_time;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_meas(input string tag, input int c, input int ep, input int eh);
    chk({tag, "_vld"}, 32'(mv_h[c]), 32'd1);
    chk({tag, "_period"}, 32'(p_h[c]), 32'(ep));
    chk({tag, "_high"}, 32'(h_h[c]), 32'(eh));
  endtask

  task automatic no_valid(input string tag, input int a, input int b);
    int n;
    n = 0;
    for (int c = a; c <= b; c++) if (mv_h[c] !== 1'b0) n++;
    chk(tag, 32'(n), 32'd0);
  endtask

  task automatic no_timeout(input string tag, input int a, input int b);
    int n;
    n = 0;
    for (int c = a; c <= b; c++) if (tm_h[c] !== 1'b0) n++;
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    int b, s, r, t, u, v, w, rr;

    // Reset state
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_time), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;

    // 4 high / 3 low: first measurement on the 2nd rise, then every 7 cycles
    b = cyc;
    wave(4, 3, 4);
    no_valid("s1_no_first", b + 1, b + 7 + LAT);
    chk_meas("s1_m1", b + 8 + LAT, 7, 4);
    chk("s1_pulse_len", 32'(mv_h[b + 9 + LAT]), 32'd0);
    chk("s1_hold_period", 32'(p_h[b + 9 + LAT]), 32'd7);
    chk_meas("s1_m2", b + 15 + LAT, 7, 4);
    chk_meas("s1_m3", b + 22 + LAT, 7, 4);
    no_valid("s1_gap", b + 16 + LAT, b + 21 + LAT);

    // Switch to 2 high / 6 low mid-period: one mixed 4/6 period, then 8/2
    s = cyc;
    repeat (4) step(1'b1);
    repeat (6) step(1'b0);
    wave(2, 6, 3);
    chk_meas("s2_last_old", s + 1 + LAT, 7, 4);
    chk_meas("s2_mixed", s + 11 + LAT, 10, 4);
    chk_meas("s2_new1", s + 19 + LAT, 8, 2);
    chk_meas("s2_new2", s + 27 + LAT, 8, 2);

    // One rise then hold low: timeout 21 cycles after the rise cycle
    step(1'b1);
    r = cyc;
    repeat (25) step(1'b0);
    chk_meas("s3_pre", r + LAT, 8, 2);
    chk("s3_tmo_before", 32'(tm_h[r + 19 + LAT]), 32'd0);
    chk("s3_tmo_set", 32'(tm_h[r + 20 + LAT]), 32'd1);
    chk("s3_tmo_period", 32'(p_h[r + 20 + LAT]), 32'd8);
    chk("s3_tmo_high", 32'(h_h[r + 20 + LAT]), 32'd2);
    no_valid("s3_no_valid", r + 1 + LAT, r + 25);

    // Resume at 5 high / 5 low: timeout clears on 1st rise, valid on 2nd
    t = cyc;
    wave(5, 5, 3);
    chk("s3_tmo_held", 32'(tm_h[t + LAT]), 32'd1);
    chk("s3_tmo_clear", 32'(tm_h[t + 1 + LAT]), 32'd0);
    no_valid("s3_resume_nv", t + 1, t + 10 + LAT);
    chk_meas("s3_resume1", t + 11 + LAT, 10, 5);
    chk_meas("s3_resume2", t + 21 + LAT, 10, 5);

    // Minimum waveform: 1 high / 1 low
    u = cyc;
    wave(1, 1, 5);
    chk_meas("s4_close", u + 1 + LAT, 10, 5);
    chk_meas("s4_min1", u + 3 + LAT, 2, 1);
    chk("s4_min_gap", 32'(mv_h[u + 4 + LAT]), 32'd0);
    chk_meas("s4_min2", u + 5 + LAT, 2, 1);
    chk_meas("s4_min3", u + 7 + LAT, 2, 1);

    // Period exactly TIMEOUT is reported, with no timeout
    v = cyc;
    wave(1, 19, 2);
    chk_meas("s4_pre20", v + 1 + LAT, 2, 1);
    chk_meas("s4_p20", v + 21 + LAT, 20, 1);
    no_timeout("s4_p20_tmo", v + 1, v + 40);

    // Reset for one cycle mid-period of a 4/3 waveform, sig_in high
    w = cyc;
    wave(4, 3, 2);
    chk_meas("s5_pre", w + 8 + LAT, 7, 4);
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    step(1'b1);
    rr = cyc;
    chk("s5_rst_period", 32'(period), 32'd0);
    chk("s5_rst_high", 32'(high_time), 32'd0);
    chk("s5_rst_valid", 32'(meas_valid), 32'd0);
    chk("s5_rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    step(1'b1);
    repeat (3) step(1'b0);
    wave(4, 3, 2);
    no_valid("s5_nv", rr, rr + 4 + LAT);
    chk_meas("s5_m1", rr + 5 + LAT, 4, 1);
    chk_meas("s5_m2", rr + 12 + LAT, 7, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
